// File: rtl/sync_ptr_cmp.sv
// Destination-domain half of a dual-clock FIFO pointer path.
// A remote Gray pointer passes through a flop-chain synchronizer and is
// converted to binary. It is then compared against the local pointer to
// produce registered occupancy and full/empty plus almost flags. A sticky
// monitor catches synchronized Gray samples that moved by more than one bit.
module sync_ptr_cmp #(
  parameter int PTR_WIDTH   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 0
) (
  input  logic                 clk_out,
  input  logic                 rst_out_n,
  input  logic [PTR_WIDTH:0]   ptr_gray_in,
  input  logic [PTR_WIDTH:0]   local_ptr_next,
  input  logic [PTR_WIDTH:0]   thresh,
  input  logic                 err_clr,
  output logic [PTR_WIDTH:0]   ptr_sync_gray,
  output logic [PTR_WIDTH:0]   ptr_sync_bin,
  output logic [PTR_WIDTH:0]   level,
  output logic                 flag,
  output logic                 almost_flag,
  output logic                 gray_err
);

  localparam logic [PTR_WIDTH:0] DEPTH    = {1'b1, {PTR_WIDTH{1'b0}}};
  localparam logic [PTR_WIDTH:0] ONE      = {{PTR_WIDTH{1'b0}}, 1'b1};
  // The read side powers up empty; the write side powers up not-full.
  localparam logic               FLAG_RST = (MODE != 0);

  logic [PTR_WIDTH:0] sync_p [SYNC_STAGES];
  logic [PTR_WIDTH:0] prev_gray;
  logic               mon_armed;
  logic [PTR_WIDTH:0] level_nxt;
  logic               flag_nxt;
  logic               almost_nxt;

  function automatic logic [PTR_WIDTH:0] gray2bin(input logic [PTR_WIDTH:0] g);
    logic [PTR_WIDTH:0] b;
    b[PTR_WIDTH] = g[PTR_WIDTH];
    for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when more than one bit is set: clearing the lowest set bit leaves
  // something behind.
  function automatic logic multi_bit(input logic [PTR_WIDTH:0] d);
    return (d & (d - ONE)) != '0;
  endfunction

  // Plain flop chain; nothing may sit between stages.
  always_ff @(posedge clk_out or negedge rst_out_n) begin
    if (!rst_out_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
    end else begin
      sync_p[0] <= ptr_gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  assign ptr_sync_gray = sync_p[SYNC_STAGES-1];

  // Register the binary form of the synchronized pointer.
  always_ff @(posedge clk_out or negedge rst_out_n) begin
    if (!rst_out_n) ptr_sync_bin <= '0;
    else            ptr_sync_bin <= gray2bin(ptr_sync_gray);
  end

  // Modular distance between the pointers; the lap bit makes wraps fall out naturally.
  // Using local_ptr_next keeps the flags coherent with the local pointer register.
  always_comb begin
    level_nxt  = '0;
    flag_nxt   = 1'b0;
    almost_nxt = 1'b0;
    if (MODE == 0) begin
      level_nxt  = local_ptr_next - ptr_sync_bin;
      flag_nxt   = (level_nxt == DEPTH);
      almost_nxt = (level_nxt >= thresh);
    end else begin
      level_nxt  = ptr_sync_bin - local_ptr_next;
      flag_nxt   = (level_nxt == '0);
      almost_nxt = (level_nxt <= thresh);
    end
  end

  // Registered occupancy and flags.
  always_ff @(posedge clk_out or negedge rst_out_n) begin
    if (!rst_out_n) begin
      level       <= '0;
      flag        <= FLAG_RST;
      almost_flag <= FLAG_RST;
    end else begin
      level       <= level_nxt;
      flag        <= flag_nxt;
      almost_flag <= almost_nxt;
    end
  end

  // Sticky Gray monitor; skips the first edge after reset, and a new violation beats err_clr.
  always_ff @(posedge clk_out or negedge rst_out_n) begin
    if (!rst_out_n) begin
      prev_gray <= '0;
      mon_armed <= 1'b0;
      gray_err  <= 1'b0;
    end else begin
      prev_gray <= ptr_sync_gray;
      mon_armed <= 1'b1;
      if (mon_armed && multi_bit(ptr_sync_gray ^ prev_gray)) gray_err <= 1'b1;
      else if (err_clr)                                       gray_err <= 1'b0;
    end
  end

endmodule
